stream_fifo: RTL and testbench



---
 rtl/example_pkg.sv | 15 +
 rtl/fifo_sdp_ram.sv | 23 ++
 rtl/stream_fifo.sv | 73 +++++++
 tb/tb_stream_fifo.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/example_pkg.sv
// Shared constants, payload type and width helper for the stream FIFO and its bench.
package example_pkg;

  localparam int EX_DATA_W = 8;
  localparam int EX_DEPTH  = 16;
  localparam int EX_AF_LVL = 12;

  typedef logic [EX_DATA_W-1:0] ex_data_t;

  // Occupancy needs one bit more than the pointers so that DEPTH itself is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module fifo_sdp_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready stream FIFO with first-word-fall-through head, almost-full flag
// and a sticky overflow flag.
module stream_fifo
  import example_pkg::*;
#(
  parameter int DATA_W = EX_DATA_W,
  parameter int DEPTH  = EX_DEPTH,
  parameter int AF_LVL = EX_AF_LVL
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_W-1:0]         s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_W-1:0]         m_data,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      almost_full,
  output logic                      ovf_err,
  input  logic                      clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          wr_fire;
  logic          rd_fire;

  // Flags come only from the registered count, so no input reaches an output combinationally.
  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign s_ready     = !full;
  assign m_valid     = !empty;
  assign almost_full = (count >= CW'(AF_LVL));
  assign wr_fire     = s_valid && s_ready;
  assign rd_fire     = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
      if (wr_fire && !rd_fire)      count <= count + CW'(1);
      else if (rd_fire && !wr_fire) count <= count - CW'(1);
      // Set has priority over clear so a violation in the clearing cycle is not lost.
      if (s_valid && !s_ready) ovf_err <= 1'b1;
      else if (clr_err)        ovf_err <= 1'b0;
    end
  end

  // Writes are suppressed during reset so a discarded beat never lands in storage.
  fifo_sdp_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (wr_fire && rst_n),
    .waddr(wr_ptr),
    .wdata(s_data),
    .raddr(rd_ptr),
    .rdata(m_data)
  );

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo with a reference occupancy model and a data scoreboard.
module tb_stream_fifo;
  import example_pkg::*;

  localparam int DW    = EX_DATA_W;
  localparam int DEPTH = EX_DEPTH;
  localparam int AF    = EX_AF_LVL;
  localparam int CW    = cnt_w(EX_DEPTH);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          ovf_err;
  logic          clr_err;

  always #5 clk = ~clk;

  stream_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LVL(AF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .count      (count),
    .almost_full(almost_full),
    .ovf_err    (ovf_err),
    .clr_err    (clr_err)
  );

  ex_data_t q[$];
  int       mcnt;
  logic     movf;
  int       total;
  int       passed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Check outputs against the model, then advance model and DUT by one edge.
  task automatic cycle();
    bit wf;
    bit rf;
    bit was_full;
    chk("s_ready", 32'(s_ready), 32'(mcnt != DEPTH));
    chk("m_valid", 32'(m_valid), 32'(mcnt != 0));
    chk("count", 32'(count), 32'(mcnt));
    chk("almost_full", 32'(almost_full), 32'(mcnt >= AF));
    chk("ovf_err", 32'(ovf_err), 32'(movf));
    if (mcnt != 0) chk("m_data", 32'(m_data), 32'(q[0]));
    was_full = (mcnt == DEPTH);
    wf = rst_n && s_valid && !was_full;
    rf = rst_n && m_ready && (mcnt != 0);
    if (!rst_n) begin
      mcnt = 0;
      q.delete();
      movf = 1'b0;
    end else begin
      if (rf) void'(q.pop_front());
      if (wf) q.push_back(s_data);
      mcnt = mcnt + int'(wf) - int'(rf);
      if (s_valid && was_full) movf = 1'b1;
      else if (clr_err)        movf = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(base + i);
      cycle();
    end
    s_valid = 1'b0;
  endtask

  initial begin
    int idx;
    int guard;
    bit fire;
    total   = 0;
    passed  = 0;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    clr_err = 1'b0;
    mcnt    = 0;
    movf    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle after reset
    repeat (10) cycle();

    // Fill to full, then drain in order
    write_n(16, 1);
    cycle();
    chk("full_count", 32'(count), 32'(16));
    m_ready = 1'b1;
    repeat (16) cycle();
    m_ready = 1'b0;
    cycle();
    chk("drained_m_valid", 32'(m_valid), 32'(0));

    // Simultaneous read/write while full, then overflow clear
    write_n(16, 1);
    s_valid = 1'b1;
    s_data  = 8'hAA;
    m_ready = 1'b1;
    cycle();
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk("ovf_set", 32'(ovf_err), 32'(1));
    chk("ovf_count", 32'(count), 32'(15));
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;
    chk("ovf_clr", 32'(ovf_err), 32'(0));
    m_ready = 1'b1;
    repeat (15) cycle();
    m_ready = 1'b0;
    cycle();

    // Steady streaming at occupancy 5
    write_n(5, 8'h30);
    s_valid = 1'b1;
    m_ready = 1'b1;
    repeat (200) begin
      s_data = DW'($urandom);
      cycle();
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    cycle();
    chk("stream_count", 32'(count), 32'(5));
    m_ready = 1'b1;
    repeat (5) cycle();
    m_ready = 1'b0;
    cycle();

    // Pointer wrap with a toggling consumer
    idx   = 0;
    guard = 0;
    while ((idx < 20 || mcnt != 0) && guard < 200) begin
      s_valid = (idx < 20);
      s_data  = DW'(8'h80 + idx);
      m_ready = guard[0];
      fire    = s_valid && (mcnt != DEPTH);
      cycle();
      if (fire) idx++;
      guard++;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk("wrap_timeout", 32'(guard < 200), 32'(1));
    chk("wrap_ovf", 32'(ovf_err), 32'(0));
    cycle();

    // Reset mid-stream at occupancy 9
    write_n(9, 8'h40);
    cycle();
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hEE;
    m_ready = 1'b1;
    cycle();
    rst_n   = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_m_valid", 32'(m_valid), 32'(0));
    chk("rst_s_ready", 32'(s_ready), 32'(1));
    write_n(1, 8'h5A);
    cycle();
    chk("post_rst_head", 32'(m_data), 32'(8'h5A));
    m_ready = 1'b1;
    cycle();
    m_ready = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
